// File: rtl/div_ctrl_if.sv
// Handshake, result and divider-core bundle for div_ctrl.
// slave: the controller side; master: producer/consumer/core side.
interface div_ctrl_if #(
    parameter int N_BITS = 32
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              signed_i;
    logic [N_BITS-1:0] n_i;
    logic [N_BITS-1:0] d_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [N_BITS-1:0] q_o;
    logic [N_BITS-1:0] r_o;
    logic              err_o;
    logic              core_en_o;
    logic [N_BITS-1:0] core_n_o;
    logic [N_BITS-1:0] core_d_o;
    logic [N_BITS-1:0] core_q_i;
    logic [N_BITS-1:0] core_r_i;
    logic              core_valid_i;

    modport slave (
        input  flush_i, in_valid_i, signed_i, n_i, d_i,
        input  out_ready_i, core_q_i, core_r_i, core_valid_i,
        output in_ready_o, out_valid_o, q_o, r_o, err_o,
        output core_en_o, core_n_o, core_d_o
    );

    modport master (
        output flush_i, in_valid_i, signed_i, n_i, d_i,
        output out_ready_i, core_q_i, core_r_i, core_valid_i,
        input  in_ready_o, out_valid_o, q_o, r_o, err_o,
        input  core_en_o, core_n_o, core_d_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Divider front/back-end: operand conditioning, core sequencing, sign fix-up.
// Optional signed support is compiled in with DIV_CTRL_SIGNED_EN.
module div_ctrl #(
    parameter int N_BITS   = 32,
    parameter int CORE_LAT = 16
) (
    input logic       clk_i,
    input logic       rst_n_i,
    div_ctrl_if.slave bus
);
    localparam int CW = $clog2(CORE_LAT + 2);
    localparam logic [N_BITS-1:0] MIN = {1'b1, {(N_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              sign_q, sign_q_d;
    logic              sign_r, sign_r_d;
    logic [N_BITS-1:0] core_n, core_n_d;
    logic [N_BITS-1:0] core_d, core_d_d;
    logic [N_BITS-1:0] q, q_d;
    logic [N_BITS-1:0] r, r_d;
    logic              err, err_d;

    logic              sgn;
    logic              ovf;
    logic              neg_n, neg_d;
    logic [N_BITS-1:0] abs_n, abs_d;
    logic              d_zero;
    logic              timeout;

`ifdef DIV_CTRL_SIGNED_EN
    assign sgn = bus.signed_i;
    assign ovf = sgn && (bus.n_i == MIN) && (bus.d_i == '1);
`else
    logic unused_signed;
    assign unused_signed = bus.signed_i;
    assign sgn = 1'b0;
    assign ovf = 1'b0;
`endif

    assign neg_n   = sgn & bus.n_i[N_BITS-1];
    assign neg_d   = sgn & bus.d_i[N_BITS-1];
    assign abs_n   = neg_n ? -bus.n_i : bus.n_i;
    assign abs_d   = neg_d ? -bus.d_i : bus.d_i;
    assign d_zero  = (bus.d_i == '0);
    assign timeout = (cnt == CW'(CORE_LAT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            core_n <= '0;
            core_d <= '0;
            q      <= '0;
            r      <= '0;
            err    <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            sign_q <= sign_q_d;
            sign_r <= sign_r_d;
            core_n <= core_n_d;
            core_d <= core_d_d;
            q      <= q_d;
            r      <= r_d;
            err    <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sign_q_d = sign_q;
        sign_r_d = sign_r;
        core_n_d = core_n;
        core_d_d = core_d;
        q_d      = q;
        r_d      = r;
        err_d    = err;
        unique case (state)
            IDLE: begin
                if (bus.in_valid_i && !bus.flush_i) begin
                    sign_q_d = neg_n ^ neg_d;
                    sign_r_d = neg_n;
                    core_n_d = abs_n;
                    core_d_d = abs_d;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    if (d_zero) begin
                        q_d     = '1;
                        r_d     = bus.n_i;
                        state_d = DONE;
                    end else if (ovf) begin
                        q_d     = MIN;
                        r_d     = '0;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt + 1'b1;
                if (bus.flush_i) begin
                    // keep the core enabled until it returns so it restarts clean
                    cnt_d   = '0;
                    state_d = bus.core_valid_i ? IDLE : DRAIN;
                end else if (bus.core_valid_i) begin
                    q_d     = sign_q ? -bus.core_q_i : bus.core_q_i;
                    r_d     = sign_r ? -bus.core_r_i : bus.core_r_i;
                    state_d = DONE;
                end else if (timeout) begin
                    q_d     = '0;
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                cnt_d = cnt + 1'b1;
                if (bus.core_valid_i || timeout) state_d = IDLE;
            end
            DONE: begin
                if (bus.flush_i || bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready_o  = (state == IDLE);
    assign bus.out_valid_o = (state == DONE);
    assign bus.core_en_o   = (state == RUN) || (state == DRAIN);
    assign bus.core_n_o    = core_n;
    assign bus.core_d_o    = core_d;
    assign bus.q_o         = q;
    assign bus.r_o         = r;
    assign bus.err_o       = err;
endmodule
